// File: rtl/pipeline_register.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_register
// Purpose  : Elastic DEPTH-stage valid/ready register chain with combinational
//            ready propagation, bubble collapsing and synchronous flush.
//            Optional occupancy port enabled by macro PIPE_REG_COUNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_register #(
  parameter int WORD_LENGTH = 32,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  localparam int COUNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WORD_LENGTH-1:0] r_data;
  logic [DEPTH-1:0]                  r_valid;
  logic [DEPTH-1:0]                  w_move;
  logic [DEPTH-1:0]                  w_valid_next;

  // A stage may advance when it is empty or the stage ahead of it advances,
  // so empty stages ahead of a stall still fill (bubble collapse).
  always_comb begin
    w_move            = '0;
    w_move[DEPTH-1]   = ~r_valid[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_move[i] = ~r_valid[i] | w_move[i+1];
    end
  end

  always_comb begin
    w_valid_next = r_valid;
    if (flush) begin
      w_valid_next = '0;
    end else begin
      if (w_move[0]) w_valid_next[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_move[i]) w_valid_next[i] = r_valid[i-1];
      end
    end
  end

  // Data only loads from a valid source, so empty stages never disturb it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_next;
      if (w_move[0] && in_valid) r_data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_move[i] && r_valid[i-1]) r_data[i] <= r_data[i-1];
      end
    end
  end

  assign in_ready  = w_move[0] & ~flush;
  assign out_data  = r_data[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];

`ifdef PIPE_REG_COUNT_EN
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + COUNT_W'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_count <= '0;
    else        r_count <= w_count_next;
  end

  assign count = r_count;
`endif

endmodule
`default_nettype wire
